// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package ex_hazard_ctrl_pkg;

   // Operand-select encodings for the E-stage ALU input muxes
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } md_state_t;

   // Register-number match; $zero is hard-wired and never produces a hazard
   function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/ex_hazard_ctrl_md_seq.sv
// Multi-cycle multiply/divide sequencer: holds the instruction in E while
// BUSY and pulses MdLatch for one cycle in DONE to write HI/LO.
module md_seq
   import ex_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic MdStartE,
   output logic mdstall,
   output logic MdBusy,
   output logic MdLatch
);

   localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

   md_state_t  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   // State and down-counter registers; async reset drops any op in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter update and the stall request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mdstall = 1'b0;
      case (state_q)
         IDLE: begin
            if (MdStartE) begin
               state_d = BUSY;
               cnt_d   = MD_LOAD;
               mdstall = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            mdstall = 1'b1;
            if (cnt_q == 8'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE: begin
            // Always return to IDLE so a still-asserted MdStartE of the
            // retiring instruction cannot restart the unit
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign MdBusy  = (state_q != IDLE);
   assign MdLatch = (state_q == DONE);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: operand forwarding,
// load-use / branch stalls, multiply/divide hold and stall-cycle counter.
module ex_hazard_ctrl
   import ex_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 32,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             MdStartE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushE,
   output logic             FlushM,
   output logic             MdBusy,
   output logic             MdLatch,
   output logic [CNT_W-1:0] StallCount
);

   logic             mdstall_s;
   logic             lwstall_s;
   logic             brstall_s;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   md_seq #(.MD_CYCLES(MD_CYCLES)) u_md_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .MdStartE (MdStartE),
      .mdstall  (mdstall_s),
      .MdBusy   (MdBusy),
      .MdLatch  (MdLatch)
   );

   // E-stage operand forwarding; the younger M result wins over W
   always_comb begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (RegWriteM && reg_hit(RsE, WriteRegM)) begin
         ForwardAE = FWD_MEM;
      end else if (RegWriteW && reg_hit(RsE, WriteRegW)) begin
         ForwardAE = FWD_WB;
      end else begin
         ForwardAE = FWD_RF;
      end
      if (RegWriteM && reg_hit(RtE, WriteRegM)) begin
         ForwardBE = FWD_MEM;
      end else if (RegWriteW && reg_hit(RtE, WriteRegW)) begin
         ForwardBE = FWD_WB;
      end else begin
         ForwardBE = FWD_RF;
      end
   end

   // D-stage branch compare forwarding and stall/flush generation
   always_comb begin
      ForwardAD = RegWriteM & reg_hit(RsD, WriteRegM);
      ForwardBD = RegWriteM & reg_hit(RtD, WriteRegM);
      lwstall_s = MemtoRegE & (reg_hit(RtE, RsD) | reg_hit(RtE, RtD));
      brstall_s = BranchD &
                  ((RegWriteE & (reg_hit(WriteRegE, RsD) | reg_hit(WriteRegE, RtD))) |
                   (MemtoRegM & (reg_hit(WriteRegM, RsD) | reg_hit(WriteRegM, RtD))));
      StallF    = lwstall_s | brstall_s | mdstall_s;
      StallD    = lwstall_s | brstall_s | mdstall_s;
      StallE    = mdstall_s;
      FlushM    = mdstall_s;
      // A held E register keeps its instruction, so it must not be bubbled
      FlushE    = (lwstall_s | brstall_s) & ~mdstall_s;
   end

   // Saturating stall-cycle count for performance debug
   always_comb begin
      if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed test-plan sequences followed
// by randomized traffic, checked against a cycle-level reference model.
module tb_ex_hazard_ctrl;

   localparam int MDC = 4;
   localparam int CW  = 4;

   typedef struct packed {
      logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
      logic       rwe, rwm, rww, mre, mrm, brd, mds;
   } stim_t;

   typedef struct packed {
      logic [1:0]    fae, fbe;
      logic          fad, fbd, sf, sd, se, fe, fm, busy, latch;
      logic [CW-1:0] cnt;
   } out_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] RsD = 5'd0, RtD = 5'd0, RsE = 5'd0, RtE = 5'd0;
   logic [4:0] WriteRegE = 5'd0, WriteRegM = 5'd0, WriteRegW = 5'd0;
   logic RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
   logic MemtoRegE = 1'b0, MemtoRegM = 1'b0, BranchD = 1'b0, MdStartE = 1'b0;
   logic [1:0] ForwardAE, ForwardBE;
   logic ForwardAD, ForwardBD, StallF, StallD, StallE, FlushE, FlushM, MdBusy, MdLatch;
   logic [CW-1:0] StallCount;

   ex_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .MdStartE(MdStartE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushE(FlushE), .FlushM(FlushM),
      .MdBusy(MdBusy), .MdLatch(MdLatch), .StallCount(StallCount)
   );

   always #5 clk = ~clk;

   out_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state: cycles elapsed since the md op was first seen
   // (-1 when no op is in flight) and the number of stalled cycles so far.
   int md_k  = -1;
   int cnt_m = 0;

   function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
      return (a == b) && (a != 5'd0);
   endfunction

   function automatic logic [1:0] fwd(input logic [4:0] src, input stim_t s);
      if (s.rwm && hit(src, s.wrm)) return 2'b10;
      if (s.rww && hit(src, s.wrw)) return 2'b01;
      return 2'b00;
   endfunction

   // Apply one cycle of stimulus and push what the DUT must show this cycle
   task automatic step(input stim_t s, input logic rst);
      out_t e;
      bit   lw, br, md, busy, latch;
      int   next_k;
      @(posedge clk);
      #1;
      RsD = s.rsd; RtD = s.rtd; RsE = s.rse; RtE = s.rte;
      WriteRegE = s.wre; WriteRegM = s.wrm; WriteRegW = s.wrw;
      RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww;
      MemtoRegE = s.mre; MemtoRegM = s.mrm; BranchD = s.brd; MdStartE = s.mds;
      rst_n = rst;
      if (!rst) begin
         md_k  = -1;
         cnt_m = 0;
      end
      if (md_k < 0) begin
         md = s.mds; busy = 1'b0; latch = 1'b0;
         next_k = s.mds ? 1 : -1;
      end else if (md_k <= MDC) begin
         md = 1'b1; busy = 1'b1; latch = 1'b0;
         next_k = md_k + 1;
      end else begin
         md = 1'b0; busy = 1'b1; latch = 1'b1;
         next_k = -1;
      end
      lw = s.mre && (hit(s.rte, s.rsd) || hit(s.rte, s.rtd));
      br = s.brd && ((s.rwe && (hit(s.wre, s.rsd) || hit(s.wre, s.rtd))) ||
                     (s.mrm && (hit(s.wrm, s.rsd) || hit(s.wrm, s.rtd))));
      e.fae   = fwd(s.rse, s);
      e.fbe   = fwd(s.rte, s);
      e.fad   = s.rwm && hit(s.rsd, s.wrm);
      e.fbd   = s.rwm && hit(s.rtd, s.wrm);
      e.sf    = lw || br || md;
      e.sd    = lw || br || md;
      e.se    = md;
      e.fm    = md;
      e.fe    = (lw || br) && !md;
      e.busy  = busy;
      e.latch = latch;
      e.cnt   = CW'(cnt_m);
      exp_q.push_back(e);
      if (rst) begin
         md_k = next_k;
         if (e.sd && cnt_m < (1 << CW) - 1) cnt_m = cnt_m + 1;
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation mid-cycle
   always @(negedge clk) begin
      out_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.fae = ForwardAE; a.fbe = ForwardBE; a.fad = ForwardAD; a.fbd = ForwardBD;
         a.sf = StallF; a.sd = StallD; a.se = StallE; a.fe = FlushE; a.fm = FlushM;
         a.busy = MdBusy; a.latch = MdLatch; a.cnt = StallCount;
         n_checks = n_checks + 1;
         if (a === e) begin
            n_pass = n_pass + 1;
         end else begin
            $display("FAIL outputs t=%0t got fAE=%b fBE=%b fAD=%b fBD=%b sF=%b sD=%b sE=%b fE=%b fM=%b busy=%b latch=%b cnt=%0d expected fAE=%b fBE=%b fAD=%b fBD=%b sF=%b sD=%b sE=%b fE=%b fM=%b busy=%b latch=%b cnt=%0d",
                     $time, a.fae, a.fbe, a.fad, a.fbd, a.sf, a.sd, a.se, a.fe, a.fm, a.busy, a.latch, a.cnt,
                     e.fae, e.fbe, e.fad, e.fbd, e.sf, e.sd, e.se, e.fe, e.fm, e.busy, e.latch, e.cnt);
         end
      end
   end

   initial begin
      stim_t s;
      s = '0;
      // Reset state
      step(s, 1'b0);
      step(s, 1'b0);
      step(s, 1'b1);

      // Forwarding priority M over W, W alone, $zero never matches
      s = '0; s.rwm = 1'b1; s.wrm = 5'd8; s.rww = 1'b1; s.wrw = 5'd8; s.rse = 5'd8;
      step(s, 1'b1);
      s.rwm = 1'b0;
      step(s, 1'b1);
      s.rse = 5'd0; s.rwm = 1'b1; s.wrm = 5'd0; s.wrw = 5'd0;
      step(s, 1'b1);

      // Load-use stall then clear
      s = '0; s.mre = 1'b1; s.rte = 5'd9; s.rsd = 5'd9;
      step(s, 1'b1);
      s.mre = 1'b0;
      step(s, 1'b1);
      step(s, 1'b1);

      // Branch hazards: E write, M load, then plain M forward
      s = '0; s.brd = 1'b1; s.rwe = 1'b1; s.wre = 5'd4; s.rtd = 5'd4;
      step(s, 1'b1);
      s.rwe = 1'b0; s.mrm = 1'b1; s.wrm = 5'd4;
      step(s, 1'b1);
      s.mrm = 1'b0; s.rwm = 1'b1;
      step(s, 1'b1);

      // Multiply/divide with MdStartE held through DONE
      s = '0; s.mds = 1'b1;
      for (int i = 0; i < MDC + 2; i++) step(s, 1'b1);
      s.mds = 1'b0;
      for (int i = 0; i < 3; i++) step(s, 1'b1);

      // Load-use hazard during BUSY, still present in DONE
      s = '0; s.mds = 1'b1;
      step(s, 1'b1);
      s.mds = 1'b0; s.mre = 1'b1; s.rte = 5'd9; s.rsd = 5'd9;
      for (int i = 0; i < MDC + 2; i++) step(s, 1'b1);
      s = '0;
      step(s, 1'b1);

      // Asynchronous reset in the middle of BUSY
      s = '0; s.mds = 1'b1;
      step(s, 1'b1);
      s.mds = 1'b0;
      step(s, 1'b1);
      step(s, 1'b1);
      step(s, 1'b0);
      for (int i = 0; i < 4; i++) step(s, 1'b1);

      // Randomized traffic with small register numbers to provoke matches
      for (int i = 0; i < 600; i++) begin
         s.rsd = 5'($urandom_range(0, 5)); s.rtd = 5'($urandom_range(0, 5));
         s.rse = 5'($urandom_range(0, 5)); s.rte = 5'($urandom_range(0, 5));
         s.wre = 5'($urandom_range(0, 5)); s.wrm = 5'($urandom_range(0, 5));
         s.wrw = 5'($urandom_range(0, 5));
         s.rwe = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
         s.rww = 1'($urandom_range(0, 1)); s.mre = 1'($urandom_range(0, 1));
         s.mrm = 1'($urandom_range(0, 1)); s.brd = 1'($urandom_range(0, 1));
         s.mds = ($urandom_range(0, 7) == 0);
         step(s, ($urandom_range(0, 99) != 0));
      end

      s = '0;
      step(s, 1'b1);
      step(s, 1'b1);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks = n_checks + 1;
         $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core; it configures and sequences the execute stage. It generates the execute-stage operand forwarding selects and the decode-stage branch-compare forwards. It produces load-use and branch stalls, and it runs a multi-cycle multiply/divide sequencer that holds the instruction in E until the result is latched into HI/LO. A saturating stall-cycle counter is exposed for performance debug.

## Interface
Parameters:
- MD_CYCLES, 32, number of BUSY cycles for a multiply/divide op (legal range 2..255)
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- RsD, RtD  in  5 each  source registers of the instruction in D
- RsE, RtE  in  5 each  source registers of the instruction in E
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enable in E/M/W
- MemtoRegE, MemtoRegM  in  1 each  load instruction in E/M
- BranchD  in  1  branch in D (compare resolved in D)
- MdStartE  in  1  instruction in E is multiply/divide
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 ResultW, 10 ALUOutM
- ForwardAD, ForwardBD  out  1 each  branch-compare operand taken from ALUOutM
- StallF, StallD, StallE  out  1 each  hold PC / D register / E register
- FlushE, FlushM  out  1 each  insert bubble into E / M register
- MdBusy  out  1  sequencer not IDLE
- MdLatch  out  1  one-cycle pulse: write HI/LO this cycle
- StallCount  out  CNT_W  saturating count of cycles with StallD=1

## Operation
- Register 0 never matches in any comparison below.
- ForwardAE: 10 if RegWriteM and RsE==WriteRegM. Otherwise 01 if RegWriteW and RsE==WriteRegW. Otherwise 00. ForwardBE uses the same rule with RtE. The M match has priority over the W match.
- ForwardAD = RegWriteM & RsD==WriteRegM. ForwardBD uses RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- brstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- Sequencer states are IDLE, BUSY and DONE.
  - IDLE→BUSY when MdStartE; the counter is loaded with MD_CYCLES-1.
  - BUSY decrements the counter each cycle. BUSY→DONE when the counter is 0.
  - DONE→IDLE unconditionally, even if MdStartE is still high. This prevents a retrigger on the same instruction.
- mdstall = (IDLE & MdStartE) | BUSY.
- StallF = StallD = lwstall | brstall | mdstall.
- StallE = FlushM = mdstall.
- FlushE = (lwstall | brstall) & ~mdstall. An E stage being held is never flushed.
- MdLatch = (state==DONE). MdBusy = (state!=IDLE).
- StallCount increments when StallD=1 and saturates at all-ones.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state. There are zero cycles of latency.
- For MdStartE first seen in cycle t:
  - mdstall is high in cycles t..t+MD_CYCLES, which is MD_CYCLES+1 cycles.
  - DONE and MdLatch occur in cycle t+MD_CYCLES+1. The instruction advances to M at the end of that cycle.
- A load-use hazard during BUSY is absorbed by mdstall. No FlushE occurs until the sequencer is in DONE, after which normal rules apply.
- Asynchronous reset during BUSY forces IDLE and the counter to 0 immediately. mdstall drops in the same cycle.
- Reset values: state IDLE, MdBusy 0, MdLatch 0, StallCount 0. StallE and FlushM are 0. All other outputs are combinational and are 0 when their inputs are 0.

## Structure
- Shared package holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - the md_state_t enum {IDLE, BUSY, DONE}
- One sub-module, md_seq, contains the FSM and down-counter. Its ports are clk, rst_n, MdStartE, mdstall, MdBusy and MdLatch.
- The forwarding and stall logic plus StallCount live in the top level.

## Test plan
- RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8 → ForwardAE=10. With RegWriteM=0 → ForwardAE=01. With RsE=0 → 00.
- MemtoRegE=1, RtE=9, RsD=9 → StallF=StallD=1, FlushE=1. In the next cycle, with MemtoRegE=0 → all 0. StallCount=1.
- BranchD=1, RegWriteE=1, WriteRegE=4, RtD=4 → stall with FlushE=1. Then with MemtoRegM=1, WriteRegM=4 → stall. Then with RegWriteM=1 only → ForwardBD=1 and no stall.
- MD_CYCLES=4, MdStartE held high from cycle 0 → StallE=FlushM=1 in cycles 0..4, MdLatch=1 only in cycle 5, MdBusy=0 in cycle 6. No second latch occurs.
- MdStartE with lwstall conditions true during BUSY → FlushE=0 throughout BUSY. FlushE=1 in DONE if the hazard still holds.
- Assert rst_n=0 in the middle of BUSY → MdBusy=0 and StallE=0 immediately. After release, with MdStartE=0, the design stays IDLE. StallCount=0 and stays 0 while stalls are absent.
